pc_redirect_ctrl: RTL and testbench
===================================

// Module: pc_redirect_ctrl
// PURPOSE
//  Sequencer for the fetch-stage PC unit. Arbitrates next-PC redirect sources: exception entry,
//  ERET return, taken branch, jump. Combines them with load-use stalls and drives the unit's
//  PCWrite/PCSel/PCIn plus the IF/ID and ID/EX flush lines.
//  Sits between the hazard/branch logic in ID and the PC register in IF. Holds EPC.
// PARAMETERS
//  EXC_VECTOR    32'h0000_4180  exception handler entry address
//  DRAIN_CYCLES  2              PC-hold cycles on exception entry before the vector write (>=1)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  ReSet_n    in   1   reset, asynchronous assert, active-low
//  StallReq   in   1   load-use hazard: hold PC, bubble ID/EX
//  BrTaken    in   1   branch resolved taken in ID
//  BrTarget   in   32  branch target
//  JmpReq     in   1   j/jal/jr in ID
//  JmpTarget  in   32  jump target
//  ExcReq     in   1   exception raised (1-cycle pulse)
//  ExcPC      in   32  PC of the faulting instruction
//  EretReq    in   1   eret in ID
//  PCWrite    out  1   PC update enable
//  PCSel      out  1   1: load PCIn, 0: sequential PC+4
//  PCIn       out  32  redirect target
//  FlushIFID  out  1   squash IF/ID register
//  FlushIDEX  out  1   insert bubble into ID/EX
//  EPC        out  32  saved exception PC
// BEHAVIOUR
//  - Reset (ReSet_n=0, immediate):
//    - state=RUN, PendTgt=0, EPC=0, drain count=0.
//    - Outputs forced: PCWrite=0, PCSel=0, PCIn=0, both flushes=0.
//  - Outputs are combinational from state + inputs, valid in the request cycle (zero-bubble redirect).
//    State updates on posedge clk.
//  - Priority within a cycle: ExcReq > EretReq > BrTaken > JmpReq. The redirect target R is EPC for
//    eret, else BrTarget, else JmpTarget.
//  - State RUN:
//    - ExcReq: EPC<=ExcPC; PCWrite=0; FlushIFID=FlushIDEX=1; cnt<=DRAIN_CYCLES-1.
//      -> DRAIN if DRAIN_CYCLES>1, else -> VEC. Any stall is ignored.
//    - Redirect and !StallReq: PCWrite=1, PCSel=1, PCIn=R, FlushIFID=1. Stay in RUN.
//    - Redirect and StallReq: PCWrite=0, FlushIDEX=1, PendTgt<=R. -> PEND.
//    - StallReq only: PCWrite=0, FlushIDEX=1.
//    - Idle: PCWrite=1, PCSel=0.
//  - State PEND: new Br/Jmp/Eret requests are ignored (ID is frozen, so they are repeats).
//    - StallReq=1: PCWrite=0, FlushIDEX=1.
//    - StallReq=0: PCWrite=1, PCSel=1, PCIn=PendTgt, FlushIFID=1. -> RUN.
//    - ExcReq: handled exactly as in RUN; the pending target is discarded. -> DRAIN/VEC.
//  - State DRAIN: PCWrite=0, FlushIFID=FlushIDEX=1. cnt decrements; at cnt==1 -> VEC.
//    ExcReq is ignored (the first exception wins).
//  - State VEC: PCWrite=1, PCSel=1, PCIn=EXC_VECTOR, FlushIFID=1. -> RUN. ExcReq is ignored.
//  - EPC changes only on an accepted ExcReq. An ERET issued before any exception returns to 0.
//  - Reset mid-DRAIN or mid-PEND: all state is lost; no partial redirect is emitted afterwards.
// STRUCTURE
//  - Shared header pipe_ctrl_defs: state encodings (RUN, PEND, DRAIN, VEC),
//    RESET_PC=32'h0000_3000, default EXC_VECTOR.
//  - Sub-module pc_redirect_arb: combinational priority encoder.
//    Inputs: Exc, Eret, Br, Jmp requests and targets. Outputs: any_redir, R.
//  - FSM, PendTgt, EPC and the drain counter live in the top module.
// TESTING
//  1. Release reset, no requests -> PCWrite=1, PCSel=0 every cycle; PC runs 0x3000, 0x3004, 0x3008.
//  2. BrTaken=1, BrTarget=0x3040, no stall
//     -> same cycle PCWrite=1, PCSel=1, PCIn=0x3040, FlushIFID=1; next PC=0x3040.
//  3. StallReq=1 for 2 cycles; JmpReq with JmpTarget=0x3100 in the first cycle
//     -> PCWrite=0 for 2 cycles; the cycle the stall drops shows PCIn=0x3100, PCSel=1, FlushIFID=1.
//  4. ExcReq with ExcPC=0x3020, same cycle as BrTaken to 0x3040
//     -> EPC=0x3020; 2 cycles PCWrite=0 with both flushes; then PCIn=0x4180; branch never taken.
//  5. EretReq after test 4, no stall -> PCWrite=1, PCSel=1, PCIn=0x3020, FlushIFID=1.
//  6. ReSet_n=0 during the 2nd DRAIN cycle
//     -> outputs at reset values immediately; after release, sequential fetch resumes
//        with no vector write and EPC=0.

Source files
------------

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC control slice.
//   pc_state_e        sequencer states (run, pending redirect, exception drain, vector write)
//   ResetPc           PC value the fetch PC register takes on reset
//   DefaultExcVector  default exception handler entry address
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StPend  = 2'd1,
    StDrain = 2'd2,
    StVec   = 2'd3
  } pc_state_e;

  localparam logic [31:0] ResetPc          = 32'h0000_3000;
  localparam logic [31:0] DefaultExcVector = 32'h0000_4180;

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority encoder for next-PC redirect sources.
// Priority: exception > eret > taken branch > jump. The exception itself carries no
// target here (the vector is applied later by the sequencer), so it only masks the rest.
// Ports:
//   exc_i, eret_i, br_i, jmp_i   redirect requests
//   epc_i                        eret return address
//   br_target_i, jmp_target_i    branch / jump targets
//   any_redir_o                  a non-exception redirect wins this cycle
//   redir_tgt_o                  target of the winning redirect
module pc_redirect_arb
  import pc_redirect_ctrl_pkg::*;
(
  input  logic        exc_i,
  input  logic        eret_i,
  input  logic        br_i,
  input  logic        jmp_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] jmp_target_i,
  output logic        any_redir_o,
  output logic [31:0] redir_tgt_o
);

  always_comb begin
    any_redir_o = ~exc_i & (eret_i | br_i | jmp_i);
    if (eret_i) begin
      redir_tgt_o = epc_i;
    end else if (br_i) begin
      redir_tgt_o = br_target_i;
    end else begin
      redir_tgt_o = jmp_target_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer. Arbitrates exception entry, ERET, taken branch and jump,
// merges them with load-use stalls, and drives the PC register controls plus the
// IF/ID and ID/EX flush lines. Holds EPC.
// Ports:
//   clk, ReSet_n           clock, async active-low reset
//   StallReq               load-use hazard: hold PC, bubble ID/EX
//   BrTaken, BrTarget      taken branch resolved in ID and its target
//   JmpReq, JmpTarget      jump in ID and its target
//   ExcReq, ExcPC          exception pulse and faulting PC
//   EretReq                eret in ID
//   PCWrite, PCSel, PCIn   PC update enable, select (1: PCIn, 0: PC+4), redirect target
//   FlushIFID, FlushIDEX   squash IF/ID, bubble ID/EX
//   EPC                    saved exception PC
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = DefaultExcVector,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        ReSet_n,
  input  logic        StallReq,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        JmpReq,
  input  logic [31:0] JmpTarget,
  input  logic        ExcReq,
  input  logic [31:0] ExcPC,
  input  logic        EretReq,
  output logic        PCWrite,
  output logic        PCSel,
  output logic [31:0] PCIn,
  output logic        FlushIFID,
  output logic        FlushIDEX,
  output logic [31:0] EPC
);

  localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);

  pc_state_e   state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] epc_q, epc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        any_redir;
  logic [31:0] redir_tgt;

  logic        pc_write, pc_sel, flush_ifid, flush_idex;
  logic [31:0] pc_in;

  pc_redirect_arb u_arb (
    .exc_i        (ExcReq),
    .eret_i       (EretReq),
    .br_i         (BrTaken),
    .jmp_i        (JmpReq),
    .epc_i        (epc_q),
    .br_target_i  (BrTarget),
    .jmp_target_i (JmpTarget),
    .any_redir_o  (any_redir),
    .redir_tgt_o  (redir_tgt)
  );

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    epc_d      = epc_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    pc_in      = '0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    unique case (state_q)
      StRun, StPend: begin
        if (ExcReq) begin
          // Exception entry overrides stalls and discards any pending redirect.
          epc_d      = ExcPC;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          cnt_d      = CntW'(DRAIN_CYCLES - 1);
          state_d    = (DRAIN_CYCLES > 1) ? StDrain : StVec;
        end else if (state_q == StPend) begin
          // ID is frozen, so any Br/Jmp/Eret seen here is a repeat and is ignored.
          if (StallReq) begin
            flush_idex = 1'b1;
          end else begin
            pc_write   = 1'b1;
            pc_sel     = 1'b1;
            pc_in      = pend_tgt_q;
            flush_ifid = 1'b1;
            state_d    = StRun;
          end
        end else if (any_redir) begin
          if (StallReq) begin
            flush_idex = 1'b1;
            pend_tgt_d = redir_tgt;
            state_d    = StPend;
          end else begin
            pc_write   = 1'b1;
            pc_sel     = 1'b1;
            pc_in      = redir_tgt;
            flush_ifid = 1'b1;
          end
        end else if (StallReq) begin
          flush_idex = 1'b1;
        end else begin
          pc_write = 1'b1;
        end
      end
      StDrain: begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        cnt_d      = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StVec;
        end
      end
      StVec: begin
        pc_write   = 1'b1;
        pc_sel     = 1'b1;
        pc_in      = EXC_VECTOR;
        flush_ifid = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      state_q    <= StRun;
      pend_tgt_q <= '0;
      epc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      epc_q      <= epc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Outputs are held at their reset values while reset is asserted, independent of the clock.
  assign PCWrite   = ReSet_n & pc_write;
  assign PCSel     = ReSet_n & pc_sel;
  assign PCIn      = ReSet_n ? pc_in : 32'h0;
  assign FlushIFID = ReSet_n & flush_ifid;
  assign FlushIDEX = ReSet_n & flush_idex;
  assign EPC       = epc_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;
  import pc_redirect_ctrl_pkg::*;

  typedef struct {
    logic        wr;
    logic        sel;
    logic [31:0] pin;
    logic        fi;
    logic        fx;
  } exp_t;

  logic        clk = 1'b0;
  logic        ReSet_n;
  logic        StallReq, BrTaken, JmpReq, ExcReq, EretReq;
  logic [31:0] BrTarget, JmpTarget, ExcPC;
  logic        PCWrite, PCSel, FlushIFID, FlushIDEX;
  logic [31:0] PCIn, EPC;

  logic [31:0] pc;
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  pc_redirect_ctrl #(
    .EXC_VECTOR   (32'h0000_4180),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk       (clk),
    .ReSet_n   (ReSet_n),
    .StallReq  (StallReq),
    .BrTaken   (BrTaken),
    .BrTarget  (BrTarget),
    .JmpReq    (JmpReq),
    .JmpTarget (JmpTarget),
    .ExcReq    (ExcReq),
    .ExcPC     (ExcPC),
    .EretReq   (EretReq),
    .PCWrite   (PCWrite),
    .PCSel     (PCSel),
    .PCIn      (PCIn),
    .FlushIFID (FlushIFID),
    .FlushIDEX (FlushIDEX),
    .EPC       (EPC)
  );

  always #5 clk = ~clk;

  // Fetch PC register model driven by the DUT controls.
  always @(posedge clk or negedge ReSet_n) begin
    if (!ReSet_n) pc <= ResetPc;
    else if (PCWrite) pc <= PCSel ? PCIn : pc + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge: drive one cycle of stimulus, record the expected outputs,
  // compare shortly after, then advance to the next negedge.
  task automatic step(input string tag, input logic stall, input logic br, input logic [31:0] brt,
                      input logic jmp, input logic [31:0] jmpt, input logic exc,
                      input logic [31:0] epc_in, input logic eret, input logic wr, input logic sel,
                      input logic [31:0] pin, input logic fi, input logic fx);
    exp_t e;
    StallReq  = stall;
    BrTaken   = br;
    BrTarget  = brt;
    JmpReq    = jmp;
    JmpTarget = jmpt;
    ExcReq    = exc;
    ExcPC     = epc_in;
    EretReq   = eret;
    e.wr = wr; e.sel = sel; e.pin = pin; e.fi = fi; e.fx = fx;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check_eq({tag, ".PCWrite"},   32'(PCWrite),   32'(e.wr));
    check_eq({tag, ".PCSel"},     32'(PCSel),     32'(e.sel));
    check_eq({tag, ".PCIn"},      PCIn,           e.pin);
    check_eq({tag, ".FlushIFID"}, 32'(FlushIFID), 32'(e.fi));
    check_eq({tag, ".FlushIDEX"}, 32'(FlushIDEX), 32'(e.fx));
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0);
  endtask

  initial begin
    ReSet_n = 1'b0;
    StallReq = 0; BrTaken = 0; JmpReq = 0; ExcReq = 0; EretReq = 0;
    BrTarget = '0; JmpTarget = '0; ExcPC = '0;
    @(negedge clk);
    // Reset: outputs forced low even with a request pending.
    step("rst", 0, 1, 32'h3040, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    check_eq("rst.EPC", EPC, 32'h0);
    ReSet_n = 1'b1;

    // 1. sequential fetch
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("seq.pc%0d", i), pc, 32'h3000 + 32'(4 * i));
      idle("seq");
    end

    // 2. taken branch, zero-bubble
    step("br", 0, 1, 32'h3040, 0, 0, 0, 0, 0, 1, 1, 32'h3040, 1, 0);
    check_eq("br.pc", pc, 32'h3040);

    // 3. jump under a 2-cycle stall; the repeat in the frozen cycle carries a stale target
    step("stj0", 1, 0, 0, 1, 32'h3100, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    step("stj1", 1, 0, 0, 1, 32'h3200, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    step("stj2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h3100, 1, 0);
    check_eq("stj.pc", pc, 32'h3100);

    // 4. exception beats simultaneous branch; a second exception in drain is ignored
    step("exc0", 0, 1, 32'h3040, 0, 0, 1, 32'h3020, 0, 0, 0, 32'h0, 1, 1);
    check_eq("exc.EPC", EPC, 32'h3020);
    step("exc1", 0, 0, 0, 0, 0, 1, 32'h3ead, 0, 0, 0, 32'h0, 1, 1);
    step("exc2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4180, 1, 0);
    check_eq("exc.pc", pc, 32'h4180);
    check_eq("exc.EPC2", EPC, 32'h3020);

    // 5. eret returns to EPC
    step("eret", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h3020, 1, 0);
    check_eq("eret.pc", pc, 32'h3020);

    // Exception while a redirect is pending discards the pending target
    step("pe0", 1, 1, 32'h3500, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    step("pe1", 1, 0, 0, 0, 0, 1, 32'h3028, 0, 0, 0, 32'h0, 1, 1);
    step("pe2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    step("pe3", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h4180, 1, 0);
    idle("pe4");
    check_eq("pe.pc", pc, 32'h4184);
    check_eq("pe.EPC", EPC, 32'h3028);

    // 6. reset during the second hold cycle of exception entry
    step("rd0", 0, 0, 0, 0, 0, 1, 32'h3444, 0, 0, 0, 32'h0, 1, 1);
    ReSet_n = 1'b0;
    step("rd1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    check_eq("rd.EPC", EPC, 32'h0);
    ReSet_n = 1'b1;
    check_eq("rd.pc0", pc, 32'h3000);
    idle("rd2");
    idle("rd3");
    check_eq("rd.pc2", pc, 32'h3008);

    // Eret with no prior exception returns to 0
    step("eret0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 1, 0);

    // Reset while a redirect is pending: no late redirect afterwards
    step("rp0", 1, 0, 0, 1, 32'h3600, 0, 0, 0, 0, 0, 32'h0, 0, 1);
    ReSet_n = 1'b0;
    step("rp1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    ReSet_n = 1'b1;
    idle("rp2");
    check_eq("rp.pc", pc, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
